nav_command_sequencer: RTL and testbench

Command front-end for the per-axis position integrators. Accepts pilot commands over a valid/ready handshake and drives the one-hot `mode_selector` and `pos_selector` buses consumed by the axis position datapath, shared by the x/y/z axes. Owns all select sequencing: power-up position clear, persistent velocity mode, single-cycle warp jumps with enforced cooldown, and position reset.

---
 rtl/nav_command_sequencer_if.sv | 21 ++
 rtl/nav_command_sequencer.sv | 133 +++++++++++++
 tb/tb_nav_command_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/nav_command_sequencer_if.sv
// Pilot command handshake plus the select/status buses feeding the axis position datapath.
interface nav_command_sequencer_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [3:0] mode_selector;
  logic [3:0] pos_selector;
  logic       cooldown_active;
  logic       warp_denied;
  logic       cmd_error;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, mode_selector, pos_selector, cooldown_active, warp_denied, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, mode_selector, pos_selector, cooldown_active, warp_denied, cmd_error
  );
endinterface

// File: rtl/nav_command_sequencer.sv
// Command sequencer driving the shared one-hot velocity/position selects for the x/y/z integrators.
// Owns power-up clear, persistent velocity mode, single-cycle warp with cooldown lockout, and position reset.
module nav_command_sequencer #(
  parameter int RESET_HOLD    = 2,
  parameter int WARP_COOLDOWN = 8
) (
  input logic                     clk,
  input logic                     reset,
  nav_command_sequencer_if.slave  bus
);
  localparam int CNT_MAX = (RESET_HOLD > WARP_COOLDOWN) ? RESET_HOLD : WARP_COOLDOWN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(RESET_HOLD);
  localparam logic [CW-1:0] COOL_INIT = CW'(WARP_COOLDOWN);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam logic [3:0] MODE_ZERO = 4'b0001, MODE_ATK = 4'b0010,
                         MODE_DEF  = 4'b0100, MODE_STL = 4'b1000;
  localparam logic [3:0] POS_CLEAR = 4'b0001, POS_INTEG = 4'b0010, POS_WARP = 4'b0100;

  typedef enum logic [2:0] {S_INIT, S_CRUISE, S_JUMP, S_COOLDOWN, S_CLEAR} state_e;
  typedef enum logic [2:0] {
    C_NOP, C_ATTACK, C_DEFENSE, C_STEALTH, C_WARP, C_HALT, C_RESET_POS, C_RSVD
  } cmd_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_mode;
  logic [3:0]    r_pos;
  logic          r_cmd_ready;
  logic          r_cool;
  logic          r_warp_denied;
  logic          r_cmd_error;

  logic w_accept;
  cmd_e w_cmd;
  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_cmd    = cmd_e'(bus.cmd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_cnt         <= HOLD_INIT;
      r_mode        <= MODE_ZERO;
      r_pos         <= POS_CLEAR;
      r_cmd_ready   <= 1'b0;
      r_cool        <= 1'b0;
      r_warp_denied <= 1'b0;
      r_cmd_error   <= 1'b0;
    end else begin
      r_warp_denied <= 1'b0;
      r_cmd_error   <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt <= ONE) begin
            r_state     <= S_CRUISE;
            r_cnt       <= '0;
            r_pos       <= POS_INTEG;
            r_cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_JUMP: begin
          r_state     <= S_COOLDOWN;
          r_cnt       <= COOL_INIT;
          r_pos       <= POS_INTEG;
          r_cmd_ready <= 1'b1;
          r_cool      <= 1'b1;
        end
        S_CLEAR: begin
          r_state     <= S_CRUISE;
          r_pos       <= POS_INTEG;
          r_cmd_ready <= 1'b1;
        end
        S_CRUISE, S_COOLDOWN: begin
          // Cooldown keeps counting regardless of commands; RESET_POS below overrides it.
          if (r_state == S_COOLDOWN) begin
            if (r_cnt <= ONE) begin
              r_state <= S_CRUISE;
              r_cnt   <= '0;
              r_cool  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          if (w_accept) begin
            case (w_cmd)
              C_ATTACK:  r_mode <= MODE_ATK;
              C_DEFENSE: r_mode <= MODE_DEF;
              C_STEALTH: r_mode <= MODE_STL;
              C_HALT:    r_mode <= MODE_ZERO;
              C_WARP: begin
                if (r_state == S_COOLDOWN) begin
                  r_warp_denied <= 1'b1;
                end else begin
                  r_state     <= S_JUMP;
                  r_pos       <= POS_WARP;
                  r_cmd_ready <= 1'b0;
                end
              end
              C_RESET_POS: begin
                r_state     <= S_CLEAR;
                r_cnt       <= '0;
                r_pos       <= POS_CLEAR;
                r_mode      <= MODE_ZERO;
                r_cmd_ready <= 1'b0;
                r_cool      <= 1'b0;
              end
              C_RSVD:    r_cmd_error <= 1'b1;
              default:   ;
            endcase
          end
        end
        default: begin
          r_state     <= S_INIT;
          r_cnt       <= HOLD_INIT;
          r_mode      <= MODE_ZERO;
          r_pos       <= POS_CLEAR;
          r_cmd_ready <= 1'b0;
          r_cool      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.mode_selector   = r_mode;
  assign bus.pos_selector    = r_pos;
  assign bus.cooldown_active = r_cool;
  assign bus.warp_denied     = r_warp_denied;
  assign bus.cmd_error       = r_cmd_error;
endmodule

// File: tb/tb_nav_command_sequencer.sv
// Directed bench for nav_command_sequencer: hand-computed expectations, checked cycle by cycle.
module tb_nav_command_sequencer;
  localparam logic [2:0] NOP = 3'd0, ATK = 3'd1, DEF = 3'd2, STL = 3'd3,
                         WARP = 3'd4, HALT = 3'd5, RPOS = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  nav_command_sequencer_if bus ();

  nav_command_sequencer #(.RESET_HOLD(2), .WARP_COOLDOWN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full snapshot: mode, pos, ready, cooldown, denied, error
  task automatic snap(input string tag, input logic [3:0] m, input logic [3:0] p,
                      input logic rdy, input logic cl, input logic dn, input logic er);
    chk({tag, ".mode"}, {4'h0, bus.mode_selector}, {4'h0, m});
    chk({tag, ".pos"},  {4'h0, bus.pos_selector},  {4'h0, p});
    chk({tag, ".rdy"},  {7'h0, bus.cmd_ready},       {7'h0, rdy});
    chk({tag, ".cool"}, {7'h0, bus.cooldown_active}, {7'h0, cl});
    chk({tag, ".den"},  {7'h0, bus.warp_denied},     {7'h0, dn});
    chk({tag, ".err"},  {7'h0, bus.cmd_error},       {7'h0, er});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_assert++;
      assert ($onehot(bus.pos_selector) && $onehot(bus.mode_selector) &&
              bus.pos_selector !== 4'b1000) else begin
        n_fail++;
        $error("FAIL onehot: observed mode=%b pos=%b expected one-hot, pos!=1000",
               bus.mode_selector, bus.pos_selector);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd = NOP;

    // Reset pulse and power-up hold
    tick();
    snap("rst", 4'b0001, 4'b0001, 0, 0, 0, 0);
    mon_en = 1'b1;
    reset = 1'b0;
    tick(); snap("hold1", 4'b0001, 4'b0001, 0, 0, 0, 0);
    tick(); snap("cruise", 4'b0001, 4'b0010, 1, 0, 0, 0);

    // Back-to-back mode changes
    bus.cmd_valid = 1'b1;
    bus.cmd = ATK;  tick(); snap("atk",  4'b0010, 4'b0010, 1, 0, 0, 0);
    bus.cmd = DEF;  tick(); snap("def",  4'b0100, 4'b0010, 1, 0, 0, 0);
    bus.cmd = STL;  tick(); snap("stl",  4'b1000, 4'b0010, 1, 0, 0, 0);
    bus.cmd = HALT; tick(); snap("halt", 4'b0001, 4'b0010, 1, 0, 0, 0);
    bus.cmd = NOP;  tick(); snap("nop",  4'b0001, 4'b0010, 1, 0, 0, 0);

    // Warp, cooldown, denied warp, warp after cooldown
    bus.cmd = WARP; tick(); snap("jump", 4'b0001, 4'b0100, 0, 0, 0, 0);
    bus.cmd_valid = 1'b0;
    tick(); snap("cd1", 4'b0001, 4'b0010, 1, 1, 0, 0);
    tick(); tick();
    bus.cmd_valid = 1'b1; bus.cmd = WARP;
    tick(); snap("deny", 4'b0001, 4'b0010, 1, 1, 1, 0);
    bus.cmd_valid = 1'b0;
    tick(); snap("deny_end", 4'b0001, 4'b0010, 1, 1, 0, 0);
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk($sformatf("cool_n%0d", k), {7'h0, bus.cooldown_active}, {7'h0, (k <= 8)});
    end
    bus.cmd_valid = 1'b1; bus.cmd = WARP;
    tick(); snap("jump2", 4'b0001, 4'b0100, 0, 0, 0, 0);
    bus.cmd_valid = 1'b0;
    tick(); snap("cd2", 4'b0001, 4'b0010, 1, 1, 0, 0);

    // RESET_POS abandons cooldown; stalled WARP taken once ready returns
    bus.cmd_valid = 1'b1;
    bus.cmd = STL;  tick(); snap("cd_stl", 4'b1000, 4'b0010, 1, 1, 0, 0);
    bus.cmd = RPOS; tick(); snap("clear",  4'b0001, 4'b0001, 0, 0, 0, 0);
    bus.cmd = WARP; tick(); snap("stall",  4'b0001, 4'b0010, 1, 0, 0, 0);
    tick(); snap("jump3", 4'b0001, 4'b0100, 0, 0, 0, 0);
    bus.cmd_valid = 1'b0;
    tick(); snap("cd3", 4'b0001, 4'b0010, 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) tick();
    snap("cd3_end", 4'b0001, 4'b0010, 1, 0, 0, 0);

    // Reserved command
    bus.cmd_valid = 1'b1;
    bus.cmd = ATK;  tick(); snap("atk2", 4'b0010, 4'b0010, 1, 0, 0, 0);
    bus.cmd = RSVD; tick(); snap("rsvd", 4'b0010, 4'b0010, 1, 0, 0, 1);
    bus.cmd_valid = 1'b0;
    tick(); snap("rsvd_end", 4'b0010, 4'b0010, 1, 0, 0, 0);

    // Reset during JUMP
    bus.cmd_valid = 1'b1; bus.cmd = WARP;
    tick(); snap("jump4", 4'b0010, 4'b0100, 0, 0, 0, 0);
    bus.cmd_valid = 1'b0; reset = 1'b1;
    tick(); snap("rst_jump", 4'b0001, 4'b0001, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); snap("hold2", 4'b0001, 4'b0001, 0, 0, 0, 0);
    tick(); snap("cruise2", 4'b0001, 4'b0010, 1, 0, 0, 0);

    // WARP held through JUMP stalls, then lands in cooldown and is denied
    bus.cmd_valid = 1'b1; bus.cmd = WARP;
    tick(); snap("jump5", 4'b0001, 4'b0100, 0, 0, 0, 0);
    tick(); snap("jstall", 4'b0001, 4'b0010, 1, 1, 0, 0);
    tick(); snap("deny2", 4'b0001, 4'b0010, 1, 1, 1, 0);
    bus.cmd_valid = 1'b0;
    tick(); snap("deny2_end", 4'b0001, 4'b0010, 1, 1, 0, 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
